// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with two write ports, two combinational read ports,
// a debug read port, a per-register busy scoreboard and a sequential clear
// engine. Register 0 is hardwired to zero. The storage array itself has no
// reset: after n_rst, or after a clr_req pulse, a sweep zeroes one entry per
// cycle (indices 1 .. NREG-1) while ready is low.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : rs1/rs2 data forward same-cycle write data (w1 > w0 > stored),
//               and busy reads 0 when a same-cycle write clears it without a
//               concurrent issue of the same index.
//   undefined : reads return stored data and the registered busy bit only.
//
// Ports
//   clk                 rising-edge clock
//   n_rst               asynchronous active-low reset
//   rs1_id / rs2_id     read indices
//   rs1_data / rs2_data combinational read data
//   rs1_busy / rs2_busy scoreboard bit of the read index (0 for index 0)
//   dbg_id / dbg_data   debug read, stored value only, never bypassed
//   w0_en/w0_id/w0_data write port 0 (WB), lower priority
//   w1_en/w1_id/w1_data write port 1 (EX), higher priority
//   iss_en / iss_id     issue: mark iss_id busy
//   clr_req             pulse: re-zero the file and the scoreboard
//   ready               file usable; 0 during the clear sweep
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [AW-1:0]   rs1_id,
    input  logic [AW-1:0]   rs2_id,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic [AW-1:0]   dbg_id,
    output logic [XLEN-1:0] dbg_data,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_id,
    input  logic [XLEN-1:0] w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_id,
    input  logic [XLEN-1:0] w1_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_id,
    input  logic            clr_req,
    output logic            ready
);

    localparam int NREG = 2 ** AW;

    localparam logic [AW-1:0]   IDX_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]   IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   IDX_LAST  = {AW{1'b1}};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     idx_nxt_s;
    logic              ready_r;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;
    logic [XLEN-1:0]   regs_r [NREG];

    logic              wr_ok_s;
    logic              w0_act_s;
    logic              w1_act_s;
    logic              iss_act_s;

    logic [AW-1:0]     rd_id_s   [2];
    logic [XLEN-1:0]   rd_data_s [2];
    logic              rd_busy_s [2];
    logic [XLEN-1:0]   dbg_data_s;

    // Writes and issues only take effect in READY and not in a clr_req cycle.
    assign wr_ok_s   = (state_r == ST_READY) && !clr_req;
    assign w0_act_s  = wr_ok_s && w0_en  && (w0_id  != IDX_ZERO);
    assign w1_act_s  = wr_ok_s && w1_en  && (w1_id  != IDX_ZERO);
    assign iss_act_s = wr_ok_s && iss_en && (iss_id != IDX_ZERO);

    assign rd_id_s[0] = rs1_id;
    assign rd_id_s[1] = rs2_id;

    // State, sweep index, ready flag and scoreboard registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_CLEAR;
            idx_r   <= IDX_ONE;
            ready_r <= 1'b0;
            busy_r  <= {NREG{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            ready_r <= (state_nxt_s == ST_READY);
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state logic: sweep 1..NREG-1 in CLEAR, restart sweep on clr_req.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_CLEAR: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = ST_READY;
                    idx_nxt_s   = idx_r;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    idx_nxt_s   = idx_r + IDX_ONE;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nxt_s = ST_CLEAR;
                    idx_nxt_s   = IDX_ONE;
                end else begin
                    state_nxt_s = ST_READY;
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                idx_nxt_s   = IDX_ONE;
            end
        endcase
    end

    // Scoreboard update: writes clear, issue sets afterwards so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (!wr_ok_s) begin
            busy_nxt_s = {NREG{1'b0}};
        end else begin
            if (w0_act_s) begin
                busy_nxt_s[w0_id] = 1'b0;
            end else begin
                busy_nxt_s[w0_id] = busy_nxt_s[w0_id];
            end
            if (w1_act_s) begin
                busy_nxt_s[w1_id] = 1'b0;
            end else begin
                busy_nxt_s[w1_id] = busy_nxt_s[w1_id];
            end
            if (iss_act_s) begin
                busy_nxt_s[iss_id] = 1'b1;
            end else begin
                busy_nxt_s[iss_id] = busy_nxt_s[iss_id];
            end
        end
    end

    // Storage array: no reset; zeroed by the sweep. w1 is assigned last so it
    // overrides w0 when both target the same index.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            regs_r[idx_r] <= DATA_ZERO;
        end else begin
            if (w0_act_s) begin
                regs_r[w0_id] <= w0_data;
            end
            if (w1_act_s) begin
                regs_r[w1_id] <= w1_data;
            end
        end
    end

    // Operand read ports with optional same-cycle forwarding.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = DATA_ZERO;
            rd_busy_s[p] = 1'b0;
            if ((state_r == ST_READY) && (rd_id_s[p] != IDX_ZERO)) begin
`ifdef RF_BYPASS_EN
                if (w1_act_s && (w1_id == rd_id_s[p])) begin
                    rd_data_s[p] = w1_data;
                end else if (w0_act_s && (w0_id == rd_id_s[p])) begin
                    rd_data_s[p] = w0_data;
                end else begin
                    rd_data_s[p] = regs_r[rd_id_s[p]];
                end
                if (((w0_act_s && (w0_id == rd_id_s[p])) ||
                     (w1_act_s && (w1_id == rd_id_s[p]))) &&
                    !(iss_act_s && (iss_id == rd_id_s[p]))) begin
                    rd_busy_s[p] = 1'b0;
                end else begin
                    rd_busy_s[p] = busy_r[rd_id_s[p]];
                end
`else
                rd_data_s[p] = regs_r[rd_id_s[p]];
                rd_busy_s[p] = busy_r[rd_id_s[p]];
`endif
            end else begin
                rd_data_s[p] = DATA_ZERO;
                rd_busy_s[p] = 1'b0;
            end
        end
    end

    // Debug read: stored value only, zero during the sweep and for index 0.
    always_comb begin
        dbg_data_s = DATA_ZERO;
        if ((state_r == ST_READY) && (dbg_id != IDX_ZERO)) begin
            dbg_data_s = regs_r[dbg_id];
        end else begin
            dbg_data_s = DATA_ZERO;
        end
    end

    assign rs1_data = rd_data_s[0];
    assign rs2_data = rd_data_s[1];
    assign rs1_busy = rd_busy_s[0];
    assign rs2_busy = rd_busy_s[1];
    assign dbg_data = dbg_data_s;
    assign ready    = ready_r;

endmodule
